// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA clocking/timing pipeline.
// Holds the default counter width, the minimum legal divisor and the divisor clamp.
// Named divisor presets live here so that callers do not hard-code magic numbers.
package vga_pkg;

  localparam int CNT_W_DEF          = 16;
  localparam int DIV_MIN            = 2;
  localparam int DIV_25MHZ_FROM_100 = 4;

  // Divisors below DIV_MIN would make the period degenerate; force them up to DIV_MIN.
  function automatic logic [31:0] div_clamp(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (v < 32'(DIV_MIN)) r = 32'(DIV_MIN);
    return r;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / clock-enable generator (board clock -> pixel rate).
// Latency: out_ce first asserts on the D-th enabled edge after reset; outputs are registered.
// Backpressure: none; en=0 freezes the divider, div_load is still captured into the shadow.
module clk_div_prog
  import vga_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DIV_25MHZ_FROM_100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             out_clk,
  output logic             out_ce,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             ce_q, ce_d;

  logic [CNT_W-1:0] ld_val;
  logic             pend_any;
  logic             wrap;

  // Next-state: shadow capture, period counting, divisor swap only at period boundaries.
  always_comb begin
    ld_val   = CNT_W'(div_clamp(32'(div_val)));
    // A load in this cycle bypasses the shadow so it can take effect at this very wrap.
    shd_d    = div_load ? ld_val : shd_q;
    pend_any = div_load | pend_q;
    wrap     = (cnt_q == (div_q - ONE));

    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_any;
    clk_d  = clk_q;
    ce_d   = 1'b0;

    if (restart) begin
      cnt_d = '0;
      if (pend_any) begin
        div_d  = shd_d;
        pend_d = 1'b0;
      end
      clk_d = 1'b1;
      ce_d  = 1'b1;
    end else if (en) begin
      if (wrap) begin
        cnt_d = '0;
        ce_d  = 1'b1;
        if (pend_any) begin
          div_d  = shd_d;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // High for the first floor(D/2) counts of each period.
      clk_d = (cnt_d < (div_d >> 1));
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Divisor, shadow and pending-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= DIV_RST;
      shd_q  <= DIV_RST;
      pend_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_q <= 1'b0;
      ce_q  <= 1'b0;
    end else begin
      clk_q <= clk_d;
      ce_q  <= ce_d;
    end
  end

  assign out_clk = clk_q;
  assign out_ce  = ce_q;
  assign div_cur = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset, divisor programming, clamp, freeze, restart.
// Inputs change 1 time unit after each rising edge; outputs are checked in that same window.
// Expected values are hand-derived from the divider's period/duty rules.
module tb_clk_div_prog;

  logic        clk;
  logic        rst;
  logic        en;
  logic        restart;
  logic [15:0] div_val;
  logic        div_load;
  logic        out_clk;
  logic        out_ce;
  logic [15:0] div_cur;

  int total;
  int bad;

  clk_div_prog #(.CNT_W(16), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .div_val  (div_val),
    .div_load (div_load),
    .out_clk  (out_clk),
    .out_ce   (out_ce),
    .div_cur  (div_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled edge followed by a check of all three outputs.
  task automatic cyc(input string tag, input logic eclk, input logic ece, input logic [15:0] ediv);
    tick();
    chk({tag, ".clk"}, 32'(out_clk), 32'(eclk));
    chk({tag, ".ce"},  32'(out_ce),  32'(ece));
    chk({tag, ".div"}, 32'(div_cur), 32'(ediv));
  endtask

  // A full period of d edges starting at cnt=0; dnext is the divisor expected after its wrap.
  // Any div_load set up by the caller is dropped after the first edge.
  task automatic period(input int d, input int dnext);
    for (int k = 1; k <= d; k++) begin
      tick();
      div_load = 1'b0;
      chk($sformatf("per%0d.k%0d.clk", d, k), 32'(out_clk), 32'(((k % d) < (d / 2)) ? 1 : 0));
      chk($sformatf("per%0d.k%0d.ce", d, k),  32'(out_ce),  32'((k == d) ? 1 : 0));
      chk($sformatf("per%0d.k%0d.div", d, k), 32'(div_cur), 32'((k == d) ? dnext : d));
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    div_val  = '0;
    div_load = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst.clk", 32'(out_clk), 32'd0);
    chk("rst.ce",  32'(out_ce),  32'd0);
    chk("rst.div", 32'(div_cur), 32'd4);
    rst = 1'b1;
    en  = 1'b1;

    // 1: default divisor 4, ce on edges 4, 8, 12, clk 1,0,0,1
    period(4, 4);
    period(4, 4);
    period(4, 4);

    // 2: load 6 at cnt=1, current period still 4 long
    cyc("t2a", 1'b1, 1'b0, 16'd4);
    div_load = 1'b1; div_val = 16'd6;
    cyc("t2b", 1'b0, 1'b0, 16'd4);
    div_load = 1'b0;
    cyc("t2c", 1'b0, 1'b0, 16'd4);
    cyc("t2d", 1'b1, 1'b1, 16'd6);
    period(6, 6);
    period(6, 6);

    // 3: odd divisor 5, then clamp of 0 and 1 to 2
    div_load = 1'b1; div_val = 16'd5;
    period(6, 5);
    period(5, 5);
    period(5, 5);
    div_load = 1'b1; div_val = 16'd0;
    period(5, 2);
    period(2, 2);
    period(2, 2);
    div_load = 1'b1; div_val = 16'd1;
    period(2, 2);
    period(2, 2);

    // 4: freeze mid-period for 7 cycles
    div_load = 1'b1; div_val = 16'd4;
    period(2, 4);
    cyc("t4a", 1'b1, 1'b0, 16'd4);
    en = 1'b0;
    div_val = 16'd9;
    for (int i = 0; i < 7; i++) cyc($sformatf("t4hold%0d", i), 1'b1, 1'b0, 16'd4);
    en = 1'b1;
    cyc("t4b", 1'b0, 1'b0, 16'd4);
    cyc("t4c", 1'b0, 1'b0, 16'd4);
    cyc("t4d", 1'b1, 1'b1, 16'd4);
    period(4, 4);

    // 5: load coincident with wrap, then two loads before a wrap
    cyc("t5a", 1'b1, 1'b0, 16'd4);
    cyc("t5b", 1'b0, 1'b0, 16'd4);
    cyc("t5c", 1'b0, 1'b0, 16'd4);
    div_load = 1'b1; div_val = 16'd8;
    cyc("t5d", 1'b1, 1'b1, 16'd8);
    div_load = 1'b0;
    period(8, 8);
    div_load = 1'b1; div_val = 16'd10;
    cyc("t5e", 1'b1, 1'b0, 16'd8);
    div_val = 16'd3;
    cyc("t5f", 1'b1, 1'b0, 16'd8);
    div_load = 1'b0;
    cyc("t5g", 1'b1, 1'b0, 16'd8);
    for (int i = 4; i < 8; i++) cyc($sformatf("t5cnt%0d", i), 1'b0, 1'b0, 16'd8);
    cyc("t5h", 1'b1, 1'b1, 16'd3);
    period(3, 3);

    // 6a: asynchronous reset at cnt=2 with out_clk high
    div_load = 1'b1; div_val = 16'd8;
    period(3, 8);
    cyc("t6a", 1'b1, 1'b0, 16'd8);
    cyc("t6b", 1'b1, 1'b0, 16'd8);
    rst = 1'b0;
    #1;
    chk("t6rst.clk", 32'(out_clk), 32'd0);
    chk("t6rst.ce",  32'(out_ce),  32'd0);
    chk("t6rst.div", 32'(div_cur), 32'd4);
    tick();
    chk("t6hold.clk", 32'(out_clk), 32'd0);
    chk("t6hold.div", 32'(div_cur), 32'd4);
    rst = 1'b1;
    period(4, 4);

    // 6b: restart at cnt=2 applies a pending divisor immediately
    cyc("t6c", 1'b1, 1'b0, 16'd4);
    div_load = 1'b1; div_val = 16'd6;
    cyc("t6d", 1'b0, 1'b0, 16'd4);
    div_load = 1'b0;
    restart = 1'b1;
    cyc("t6e", 1'b1, 1'b1, 16'd6);
    restart = 1'b0;
    period(6, 6);

    // 6c: restart wins over en=0
    cyc("t6f", 1'b1, 1'b0, 16'd6);
    en = 1'b0;
    restart = 1'b1;
    cyc("t6g", 1'b1, 1'b1, 16'd6);
    restart = 1'b0;
    en = 1'b1;
    period(6, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
